// File: rtl/windower_pkg.sv
// windower_pkg: shared helpers and padding-mode selection for windower_serial.
// Build with WINDOWER_ZERO_PAD_EN defined for "same" padding output.
package windower_pkg;
  function automatic int log2_ser(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int img_size(input int log2_img);
    return 1 << log2_img;
  endfunction
`ifdef WINDOWER_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
endpackage

// File: rtl/windower_tap_delay.sv
// windower_tap_delay: enable-gated shift register with async active-low clear.
module windower_tap_delay #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_sr [DEPTH];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else if (i_en) begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end
  assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/windower_serial.sv
// windower_serial: serial sliding-window generator; emits WINDOW_SIZE beat-aligned taps.
// Optional "same" padding mode selected by WINDOWER_ZERO_PAD_EN.
module windower_serial
  import windower_pkg::*;
#(
  parameter int NO_CH_IN      = 16,
  parameter int LOG2_IMG_SIZE = 5,
  parameter int WINDOW_SIZE   = 3,
  parameter int SER_CYC       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vld_in,
  input  logic [NO_CH_IN-1:0] data_in,
  output logic                vld_out,
  output logic [NO_CH_IN-1:0] data_out [WINDOW_SIZE-1:0],
  output logic                ser_rst
);
  localparam int LB = log2_ser(SER_CYC);
  localparam logic [LB-1:0] B_LAST = LB'(SER_CYC - 1);
  localparam logic [LOG2_IMG_SIZE-1:0] S_FULL = LOG2_IMG_SIZE'(WINDOW_SIZE - 1);
  logic [LB-1:0]            r_beat;
  logic [LOG2_IMG_SIZE-1:0] r_samp;
  logic [NO_CH_IN-1:0]      w_tap  [WINDOW_SIZE];
  logic [NO_CH_IN-1:0]      w_next [WINDOW_SIZE];
  logic                     w_emit;
  logic                     w_first;
  assign w_tap[0]  = data_in;
  assign w_next[0] = data_in;
  // Each tap is one full sample (SER_CYC beats) behind the previous one.
  for (genvar k = 1; k < WINDOW_SIZE; k++) begin : g_tap
    localparam logic [LOG2_IMG_SIZE-1:0] KK = LOG2_IMG_SIZE'(k);
    windower_tap_delay #(.DEPTH(SER_CYC), .WIDTH(NO_CH_IN)) u_dly (
      .clk  (clk),
      .rst  (rst),
      .i_en (vld_in),
      .i_d  (w_tap[k-1]),
      .o_q  (w_tap[k])
    );
    // Stale taps from the previous image are zeroed while the window refills.
    assign w_next[k] = (PAD_EN && (r_samp < KK)) ? '0 : w_tap[k];
  end
  assign w_emit  = vld_in && (PAD_EN || (r_samp >= S_FULL));
  assign w_first = (r_beat == '0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat  <= '0;
      r_samp  <= '0;
      vld_out <= 1'b0;
      ser_rst <= 1'b0;
      for (int i = 0; i < WINDOW_SIZE; i++) data_out[i] <= '0;
    end else begin
      vld_out <= w_emit;
      ser_rst <= w_emit && w_first;
      if (vld_in) begin
        r_beat <= (r_beat == B_LAST) ? '0 : r_beat + 1'b1;
        if (r_beat == B_LAST) r_samp <= r_samp + 1'b1;
        for (int i = 0; i < WINDOW_SIZE; i++) data_out[i] <= w_next[i];
      end
    end
  end
endmodule

// File: tb/tb_windower_serial.sv
// tb_windower_serial: directed self-checking bench for windower_serial (default parameters).
module tb_windower_serial;
`ifdef WINDOWER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vld_in = 1'b0;
  logic [15:0] data_in = '0;
  logic        vld_out;
  logic        ser_rst;
  logic [15:0] data_out [2:0];
  int          checks = 0;
  int          errors = 0;
  int          g = 0;
  int          c = 0;
  logic [15:0] hist [0:4095];
  logic        ev = 1'b0;
  logic        esr = 1'b0;
  logic [15:0] et [3];

  windower_serial dut (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (vld_in),
    .data_in  (data_in),
    .vld_out  (vld_out),
    .data_out (data_out),
    .ser_rst  (ser_rst)
  );

  always #5 clk = ~clk;

  // Drives one cycle and advances the reference model: tap k = beat g-4k since reset.
  task automatic step(input logic v);
    int s;
    int b;
    @(negedge clk);
    vld_in  = v;
    data_in = {4{c[3:0]}};
    if (v) begin
      hist[g] = data_in;
      s   = (g / 4) % 32;
      b   = g % 4;
      ev  = PAD || (s >= 2);
      esr = ev && (b == 0);
      for (int k = 0; k < 3; k++)
        et[k] = ((g - 4 * k) >= 0 && !(PAD && k > s)) ? hist[g - 4 * k] : 16'h0000;
      g++;
      c++;
    end else begin
      ev  = 1'b0;
      esr = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vld_in  = 1'b1;
      data_in = 16'hFFFF;
      @(posedge clk);
      #1;
      if (vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", vld_out); end
      if (ser_rst !== 1'b0) begin errors++; $display("FAIL reset_ser_rst got %b exp 0", ser_rst); end
      for (int k = 0; k < 3; k++)
        if (data_out[k] !== 16'h0000) begin errors++; $display("FAIL reset_tap%0d got %h exp 0000", k, data_out[k]); end
      checks += 5;
    end
    @(negedge clk);
    vld_in = 1'b0;
    rst    = 1'b1;
    g      = 0;
    for (int k = 0; k < 3; k++) et[k] = 16'h0000;
  endtask

  task automatic test_stream();
    int nv = 0;
    int ns = 0;
    for (int n = 0; n < 128; n++) begin
      step(1'b1);
      if (vld_out) nv++;
      if (vld_out && ser_rst) ns++;
      if (vld_out !== ev) begin errors++; $display("FAIL stream_vld n=%0d got %b exp %b", n, vld_out, ev); end
      if (ser_rst !== esr) begin errors++; $display("FAIL stream_ser_rst n=%0d got %b exp %b", n, ser_rst, esr); end
      for (int k = 0; k < 3; k++)
        if (data_out[k] !== et[k]) begin errors++; $display("FAIL stream_tap%0d n=%0d got %h exp %h", k, n, data_out[k], et[k]); end
      checks += 5;
`ifdef WINDOWER_ZERO_PAD_EN
      if (n == 0 || n == 4) begin
        if (data_out[0] !== ((n == 0) ? 16'h0000 : 16'h4444) || data_out[1] !== 16'h0000 || data_out[2] !== 16'h0000 || ser_rst !== 1'b1) begin
          errors++;
          $display("FAIL pad_window n=%0d got %h %h %h sr=%b", n, data_out[0], data_out[1], data_out[2], ser_rst);
        end
        checks++;
      end
`else
      if (n == 8) begin
        if (data_out[0] !== 16'h8888 || data_out[1] !== 16'h4444 || data_out[2] !== 16'h0000 || ser_rst !== 1'b1) begin
          errors++;
          $display("FAIL first_window got %h %h %h sr=%b exp 8888 4444 0000 sr=1", data_out[0], data_out[1], data_out[2], ser_rst);
        end
        checks++;
      end
`endif
    end
    if (nv !== (PAD ? 128 : 120)) begin errors++; $display("FAIL total_vld got %0d exp %0d", nv, PAD ? 128 : 120); end
    if (ns !== 32 - (PAD ? 0 : 2)) begin errors++; $display("FAIL total_ser_rst got %0d exp %0d", ns, PAD ? 32 : 30); end
    checks += 2;
  endtask

  task automatic test_gap(input string tag);
    for (int n = 0; n < 20; n++) begin
      step(1'b0);
      if (vld_out !== 1'b0) begin errors++; $display("FAIL %s_vld n=%0d got %b exp 0", tag, n, vld_out); end
      if (ser_rst !== 1'b0) begin errors++; $display("FAIL %s_ser_rst n=%0d got %b exp 0", tag, n, ser_rst); end
      for (int k = 0; k < 3; k++)
        if (data_out[k] !== et[k]) begin errors++; $display("FAIL %s_hold%0d n=%0d got %h exp %h", tag, k, n, data_out[k], et[k]); end
      checks += 5;
    end
  endtask

  task automatic test_back_to_back();
    int start = g;
    for (int n = 0; n < 40; n++) begin
      step(1'b1);
      if (vld_out !== ev) begin errors++; $display("FAIL b2b_vld n=%0d got %b exp %b", n, vld_out, ev); end
      if (ser_rst !== esr) begin errors++; $display("FAIL b2b_ser_rst n=%0d got %b exp %b", n, ser_rst, esr); end
      for (int k = 0; k < 3; k++)
        if (data_out[k] !== et[k]) begin errors++; $display("FAIL b2b_tap%0d n=%0d got %h exp %h", k, n, data_out[k], et[k]); end
      checks += 5;
      if (n == 8) begin
        if (data_out[2] !== hist[start]) begin errors++; $display("FAIL b2b_oldest got %h exp %h", data_out[2], hist[start]); end
        checks++;
      end
    end
  endtask

  task automatic test_resume();
    test_gap("midgap");
    for (int n = 0; n < 40; n++) begin
      step(1'b1);
      if (vld_out !== ev) begin errors++; $display("FAIL resume_vld n=%0d got %b exp %b", n, vld_out, ev); end
      if (ser_rst !== esr) begin errors++; $display("FAIL resume_ser_rst n=%0d got %b exp %b", n, ser_rst, esr); end
      for (int k = 0; k < 3; k++)
        if (data_out[k] !== et[k]) begin errors++; $display("FAIL resume_tap%0d n=%0d got %h exp %h", k, n, data_out[k], et[k]); end
      checks += 5;
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    g   = 0;
    for (int n = 0; n < 50; n++) step(1'b1);
    #2;
    rst = 1'b0;
    #1;
    if (vld_out !== 1'b0) begin errors++; $display("FAIL midrst_vld got %b exp 0", vld_out); end
    if (ser_rst !== 1'b0) begin errors++; $display("FAIL midrst_ser_rst got %b exp 0", ser_rst); end
    for (int k = 0; k < 3; k++)
      if (data_out[k] !== 16'h0000) begin errors++; $display("FAIL midrst_tap%0d got %h exp 0000", k, data_out[k]); end
    checks += 5;
    vld_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    g   = 0;
    for (int k = 0; k < 3; k++) et[k] = 16'h0000;
    for (int n = 0; n < 12; n++) begin
      step(1'b1);
      if (n < 8 && vld_out) nv++;
      if (vld_out !== ev) begin errors++; $display("FAIL post_rst_vld n=%0d got %b exp %b", n, vld_out, ev); end
      if (ser_rst !== esr) begin errors++; $display("FAIL post_rst_ser_rst n=%0d got %b exp %b", n, ser_rst, esr); end
      for (int k = 0; k < 3; k++)
        if (data_out[k] !== et[k]) begin errors++; $display("FAIL post_rst_tap%0d n=%0d got %h exp %h", k, n, data_out[k], et[k]); end
      checks += 5;
    end
    if (nv !== (PAD ? 8 : 0)) begin errors++; $display("FAIL post_rst_early_vld got %0d exp %0d", nv, PAD ? 8 : 0); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gap("imggap");
    test_back_to_back();
    test_resume();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
